// File: rtl/softmax_norm_div.sv
// Softmax normalizer: latches the accumulated sum as a denominator, then divides each
// numerator by it with a bit-serial restoring divider, producing one Q(FRAC_BITS) result per element.
module softmax_norm_div #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_sum,
  input  logic [DATA_WIDTH-1:0] sum_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  div_zero,
  output logic                  busy
);
  localparam int Q  = DATA_WIDTH + FRAC_BITS;
  localparam int CW = $clog2(Q);
  localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_den;
  logic                  r_sum_ok;
  logic [DATA_WIDTH:0]   r_rem;
  logic [Q-1:0]          r_quo;
  logic [CW-1:0]         r_cnt;
  logic                  r_zflag;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_div_zero;

  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_last;
  logic [DATA_WIDTH+1:0] w_t;
  logic                  w_ge;
  logic [DATA_WIDTH:0]   w_rem_nxt;
  logic [Q-1:0]          w_quo_nxt;
  logic                  w_sat;
  logic                  w_den_le0;
  logic [DATA_WIDTH-1:0] w_num_clamped;

  assign w_in_ready    = (r_state == S_IDLE) & r_sum_ok & ~load_sum;
  assign w_accept      = in_valid & w_in_ready;
  assign w_last        = (r_cnt == CW'(Q-1));
  assign w_den_le0     = r_den[DATA_WIDTH-1] | (r_den == '0);
  assign w_num_clamped = in_data[DATA_WIDTH-1] ? '0 : in_data;

  // The dividend is shifted out of r_quo MSB-first while quotient bits shift in at the LSB.
  assign w_t       = {r_rem, r_quo[Q-1]};
  assign w_ge      = (w_t >= {2'b00, r_den});
  assign w_rem_nxt = (DATA_WIDTH+1)'(w_ge ? (w_t - {2'b00, r_den}) : w_t);
  assign w_quo_nxt = {r_quo[Q-2:0], w_ge};
  assign w_sat     = |w_quo_nxt[Q-1:DATA_WIDTH-1];

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign div_zero  = r_div_zero;
  assign busy      = (r_state != S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_DIV;
      S_DIV:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  if (r_out_valid && out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_den       <= '0;
      r_sum_ok    <= 1'b0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_cnt       <= '0;
      r_zflag     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_div_zero  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load_sum) begin
            r_den    <= sum_in;
            r_sum_ok <= 1'b1;
          end else if (w_accept) begin
            r_zflag <= w_den_le0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_quo   <= {w_num_clamped, {FRAC_BITS{1'b0}}};
          end
        end
        S_DIV: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_out_valid <= 1'b1;
            if (r_zflag) begin
              r_out_data <= MAX_POS;
              r_div_zero <= 1'b1;
            end else if (w_sat) begin
              r_out_data <= MAX_POS;
              r_div_zero <= 1'b0;
            end else begin
              r_out_data <= w_quo_nxt[DATA_WIDTH-1:0];
              r_div_zero <= 1'b0;
            end
          end
        end
        S_DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_softmax_norm_div.sv
// Self-checking bench for softmax_norm_div: directed cases plus randomized numerators and
// denominators compared against an arithmetic reference of the normalization.
module tb_softmax_norm_div;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        load_sum = 0;
  logic [15:0] sum_in = '0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [15:0] out_data;
  logic        div_zero;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int m_den = 0;

  softmax_norm_div #(.DATA_WIDTH(16), .FRAC_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .load_sum(load_sum), .sum_in(sum_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .div_zero(div_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: probability = clamp(num,0) * 2^8 / den, saturated; den <= 0 flags div_zero.
  function automatic longint ref_data(input int den, input int num);
    longint q;
    if (den <= 0) return 32767;
    q = (longint'(num < 0 ? 0 : num) * 256) / den;
    return (q > 32767) ? 32767 : q;
  endfunction

  task automatic do_load(input int s);
    @(negedge clk);
    load_sum = 1;
    sum_in   = s[15:0];
    in_valid = 1;
    #1 check("in_ready_during_load", in_ready, 0);
    @(negedge clk);
    load_sum = 0;
    in_valid = 0;
    m_den = s;
  endtask

  task automatic do_op(input int num, input int hold, input bit mid_load);
    int  lat;
    bit  stable;
    logic [15:0] d0;
    @(negedge clk);
    in_valid = 1;
    in_data  = num[15:0];
    #1 check("in_ready_idle", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
      load_sum = (mid_load && lat == 5);
      sum_in   = 16'd7;
    end
    load_sum = 0;
    check("latency", lat, 24);
    check("out_data", out_data, ref_data(m_den, num));
    check("div_zero", div_zero, (m_den <= 0) ? 1 : 0);
    check("busy_done", busy, 1);
    stable = 1;
    d0 = out_data;
    repeat (hold) begin
      @(posedge clk);
      #1 if (!out_valid || out_data !== d0 || in_ready) stable = 0;
    end
    if (hold > 0) check("hold_stable", stable, 1);
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    check("valid_after_hs", out_valid, 0);
    check("busy_after_hs", busy, 0);
  endtask

  initial begin
    int times[$];
    int acc;
    bit blocked;
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_div_zero", div_zero, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1;

    do_load(256);
    do_op(128, 0, 0);
    do_op(256, 0, 0);
    do_op(0, 0, 0);

    // back-to-back with in_valid and out_ready held high
    do_load(768);
    @(negedge clk);
    in_valid = 1;
    in_data  = 16'd256;
    out_ready = 1;
    acc = 0;
    for (int c = 0; c < 110; c++) begin
      if (in_valid && in_ready) acc++;
      @(posedge clk);
      #1 if (acc == 3) in_valid = 0;
      if (out_valid) begin
        times.push_back(c);
        check("b2b_data", out_data, 85);
      end
      @(negedge clk);
    end
    out_ready = 0;
    check("b2b_count", times.size(), 3);
    if (times.size() == 3) begin
      check("b2b_gap1", times[1] - times[0], 26);
      check("b2b_gap2", times[2] - times[1], 26);
    end

    do_load(0);
    do_op(50, 0, 0);
    do_load(-3);
    do_op(50, 0, 0);
    do_load(1);
    do_op(1000, 0, 0);
    do_load(100);
    do_op(-5, 0, 0);
    do_op(300, 10, 1);

    // asynchronous reset in the middle of a division
    do_load(256);
    @(negedge clk);
    in_valid = 1;
    in_data  = 16'd128;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (10) @(posedge clk);
    #3 rst_n = 0;
    #1 check("async_rst_busy", busy, 0);
    check("async_rst_valid", out_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    in_valid = 1;
    blocked = 1;
    repeat (5) begin
      @(negedge clk);
      #1 if (in_ready) blocked = 0;
    end
    check("no_accept_before_load", blocked, 1);
    check("busy_after_rst", busy, 0);
    in_valid = 0;
    do_load(256);
    do_op(128, 0, 0);

    for (int i = 0; i < 25; i++) begin
      if (i % 4 == 0) do_load(int'($urandom_range(0, 3000)) - 500);
      do_op(int'($urandom_range(0, 8000)) - 1000, int'($urandom_range(0, 3)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/softmax_norm_div.md
# softmax_norm_div

Sequential fixed-point normalizer at the consumer end of the softmax adder chain. It latches the accumulated sum produced by the PE adder tree as a denominator. It then divides each incoming numerator (an exponent value) by that sum, emitting Q(FRAC_BITS) probabilities one element at a time over a valid/ready stream. It uses a restoring divider that produces one quotient bit per cycle, so no hardware divider is inferred.

## Interface
- DATA_WIDTH, 16: width of sum, numerator and result.
- FRAC_BITS, 8: fractional bits of the result. Numerator is pre-shifted left by FRAC_BITS.
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- load_sum  input  1  single-cycle strobe that latches sum_in as the denominator.
- sum_in  input  DATA_WIDTH  signed accumulated sum from the PE chain.
- in_valid  input  1  numerator valid.
- in_ready  output  1  block can accept a numerator.
- in_data  input  DATA_WIDTH  signed numerator.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  DATA_WIDTH  signed quotient in Q(FRAC_BITS).
- div_zero  output  1  qualifies out_data: denominator was ≤ 0.
- busy  output  1  high in the DIV and DONE states.

## Operation
- Registers:
  - den (DATA_WIDTH): denominator.
  - sum_ok: a denominator is loaded.
  - rem (DATA_WIDTH+1): remainder.
  - quo (Q = DATA_WIDTH+FRAC_BITS): quotient.
  - cnt: counts 0..Q-1.
  - zflag.
- Reset values:
  - state = IDLE; sum_ok = 0; in_ready = 0; out_valid = 0; out_data = 0; div_zero = 0; busy = 0.
  - den, rem, quo, cnt = 0.
- State IDLE:
  - in_ready = sum_ok & ~load_sum.
  - load_sum in IDLE: den <= sum_in, sum_ok <= 1.
  - load_sum has priority over in_valid in the same cycle; in_ready is low that cycle.
  - load_sum in DIV or DONE is ignored.
- Accept occurs when in_valid & in_ready:
  - Negative in_data is clamped to 0.
  - Dividend = clamped numerator concatenated with FRAC_BITS zeros (Q bits, unsigned).
  - zflag <= (den ≤ 0). rem <= 0. cnt <= 0. state -> DIV.
- State DIV, restoring algorithm, one bit per cycle, MSB first:
  - t = {rem, next dividend bit}.
  - If t ≥ den: rem <= t - den and the quotient bit is 1. Otherwise rem <= t and the quotient bit is 0.
  - The divider runs the full Q cycles even when zflag is set; its result is then discarded.
  - After the cycle with cnt = Q-1, state -> DONE.
- Entering DONE:
  - If zflag: out_data = 2^(DATA_WIDTH-1)-1 and div_zero = 1.
  - Else if any quo bit at or above position DATA_WIDTH-1 is set: out_data = 2^(DATA_WIDTH-1)-1 (saturate) and div_zero = 0.
  - Else out_data = quo[DATA_WIDTH-1:0] and div_zero = 0.
  - out_valid = 1.
- State DONE:
  - out_data and div_zero are held stable while out_valid & ~out_ready.
  - On out_valid & out_ready: out_valid <= 0, state -> IDLE.
- den persists across elements until the next load_sum in IDLE or a reset.
- Reset asserted mid-DIV or mid-DONE: all outputs go to their reset values immediately, the result is discarded, and sum_ok is cleared. A load_sum is required before the next accept.

## Timing
- Accept edge E0. DIV occupies edges E1..EQ. out_valid is visible after edge EQ, so latency is Q cycles (24 with defaults).
- The output handshake edge returns the block to IDLE. in_ready is high from the next cycle, giving a minimum initiation interval of Q+2 cycles.
- Operations never overlap; in_ready is 0 throughout DIV and DONE.
- load_sum at edge E followed by in_valid at E+1: accepted at E+1 using the new den.
- out_ready held high while DONE is entered: the result is valid for exactly one cycle.

## Test plan
- load_sum with sum_in=256, then in_data=128 -> out_data=128 (0.5), div_zero=0, out_valid exactly 24 cycles after accept. in_data=256 -> 256. in_data=0 -> 0.
- sum_in=768, numerators 256,256,256 back-to-back with in_valid held high -> three results of 85, each 26 cycles apart, with den unchanged between them.
- sum_in=0, in_data=50 -> out_data=0x7FFF, div_zero=1, same 24-cycle latency. Repeat with sum_in=-3 -> same result.
- sum_in=1, in_data=1000 -> out_data=0x7FFF, div_zero=0 (saturation). in_data=-5 with sum_in=100 -> out_data=0.
- Hold out_ready low 10 cycles in DONE -> out_data and out_valid stable, in_ready=0. Pulse load_sum=7 during DIV -> ignored; next result still uses the old den.
- Drop rst_n at DIV cycle 10 -> out_valid=0 and busy=0 asynchronously. After release, in_ready stays 0 until load_sum.
